// File: rtl/up_counter_timer.sv
//==============================================================================
// Module   : up_counter_timer
// Brief    : Loadable up-counting interval timer (one-shot or auto-reload).
//            Optional macro UP_COUNTER_TIMER_TICK_EN adds a tick qualifier input.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module up_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             mode,
`ifdef UP_COUNTER_TIMER_TICK_EN
    input  logic             tick,
`endif
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] w_limit_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             w_tick;
    logic             w_at_limit;

`ifdef UP_COUNTER_TIMER_TICK_EN
    assign w_tick = tick;
`else
    assign w_tick = 1'b1;
`endif

    assign w_at_limit = (r_state == S_RUN) && (r_q == r_limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_q     <= c_zero;
            r_limit <= c_zero;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_limit <= w_limit_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Priority per edge: clear, then stop (RUN only), then start (IDLE/DONE only).
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_limit_nxt = r_limit;
        w_mode_nxt  = r_mode;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_q_nxt     = c_zero;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_limit_nxt = limit;
                        w_mode_nxt  = mode;
                        w_q_nxt     = c_zero;
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_tick) begin
                        if (r_q == r_limit) begin
                            if (r_mode) begin
                                w_q_nxt = c_zero;
                            end else begin
                                w_state_nxt = S_DONE;
                            end
                        end else begin
                            w_q_nxt = r_q + c_one;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_q_nxt     = c_zero;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign busy = (r_state == S_RUN);
    assign done = w_at_limit && w_tick;

endmodule

`default_nettype wire
